// File: rtl/div_scheduler.sv
// Two-channel front end that time-shares one external divider.
// Round-robin arbitration, zero-divisor short-circuit and a response timeout.
module div_scheduler #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic [1:0]         req_valid_in,
    output logic [1:0]         req_ready_out,
    input  logic [2*WIDTH-1:0] dividend_in,
    input  logic [2*WIDTH-1:0] divisor_in,
    output logic [WIDTH-1:0]   div_dividend_out,
    output logic [WIDTH-1:0]   div_divisor_out,
    output logic               div_valid_out,
    input  logic [WIDTH-1:0]   div_quotient_in,
    input  logic [WIDTH-1:0]   div_remainder_in,
    input  logic               div_valid_in,
    input  logic               div_error_in,
    output logic [2*WIDTH-1:0] quotient_out,
    output logic [2*WIDTH-1:0] remainder_out,
    output logic [1:0]         done_out,
    output logic [1:0]         error_out,
    output logic               busy_out
);

    localparam int unsigned CntW = $clog2(TIMEOUT);
    localparam logic [CntW-1:0] CntLimit = CntW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StRespond
    } state_e;

    state_e             state_q;
    logic               chan_q;
    logic               last_q;
    logic               zero_q;
    logic [CntW-1:0]    cnt_q;
    logic               div_valid_q;
    logic [WIDTH-1:0]   div_dividend_q;
    logic [WIDTH-1:0]   div_divisor_q;
    logic [2*WIDTH-1:0] quotient_q;
    logic [2*WIDTH-1:0] remainder_q;
    logic [1:0]         done_q;
    logic [1:0]         error_q;

    logic [1:0]         grant;
    logic [WIDTH-1:0]   sel_dividend;
    logic [WIDTH-1:0]   sel_divisor;

    logic               res_wr;
    logic [WIDTH-1:0]   res_quot;
    logic [WIDTH-1:0]   res_rem;
    logic               res_err;

    // With both channels pending, the one not served last wins.
    always_comb begin
        grant = 2'b00;
        if (state_q == StIdle) begin
            case (req_valid_in)
                2'b11:   grant = last_q ? 2'b01 : 2'b10;
                default: grant = req_valid_in;
            endcase
        end
    end

    always_comb begin
        sel_dividend = grant[1] ? dividend_in[2*WIDTH-1:WIDTH] : dividend_in[WIDTH-1:0];
        sel_divisor  = grant[1] ? divisor_in[2*WIDTH-1:WIDTH]  : divisor_in[WIDTH-1:0];
    end

    // Result written on the edge into RESPOND; a response beats the timeout.
    always_comb begin
        res_wr   = 1'b0;
        res_quot = '0;
        res_rem  = '0;
        res_err  = 1'b0;
        unique case (state_q)
            StIssue: begin
                if (zero_q) begin
                    res_wr  = 1'b1;
                    res_err = 1'b1;
                end
            end
            StWait: begin
                if (div_valid_in) begin
                    res_wr   = 1'b1;
                    res_quot = div_quotient_in;
                    res_rem  = div_remainder_in;
                    res_err  = div_error_in;
                end else if (cnt_q == CntLimit) begin
                    res_wr  = 1'b1;
                    res_err = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q        <= StIdle;
            chan_q         <= 1'b0;
            last_q         <= 1'b1;
            zero_q         <= 1'b0;
            cnt_q          <= '0;
            div_valid_q    <= 1'b0;
            div_dividend_q <= '0;
            div_divisor_q  <= '0;
            quotient_q     <= '0;
            remainder_q    <= '0;
            done_q         <= 2'b00;
            error_q        <= 2'b00;
        end else begin
            div_valid_q <= 1'b0;
            done_q      <= 2'b00;

            if (res_wr) begin
                if (chan_q) begin
                    quotient_q[2*WIDTH-1:WIDTH]  <= res_quot;
                    remainder_q[2*WIDTH-1:WIDTH] <= res_rem;
                    error_q[1]                   <= res_err;
                    done_q[1]                    <= 1'b1;
                end else begin
                    quotient_q[WIDTH-1:0]  <= res_quot;
                    remainder_q[WIDTH-1:0] <= res_rem;
                    error_q[0]             <= res_err;
                    done_q[0]              <= 1'b1;
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (grant != 2'b00) begin
                        chan_q <= grant[1];
                        zero_q <= (sel_divisor == '0);
                        if (sel_divisor != '0) begin
                            div_valid_q    <= 1'b1;
                            div_dividend_q <= sel_dividend;
                            div_divisor_q  <= sel_divisor;
                        end
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    cnt_q   <= '0;
                    state_q <= zero_q ? StRespond : StWait;
                end
                StWait: begin
                    if (res_wr) begin
                        div_dividend_q <= '0;
                        div_divisor_q  <= '0;
                        state_q        <= StRespond;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StRespond: begin
                    last_q  <= chan_q;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready_out    = grant;
    assign div_valid_out    = div_valid_q;
    assign div_dividend_out = div_dividend_q;
    assign div_divisor_out  = div_divisor_q;
    assign quotient_out     = quotient_q;
    assign remainder_out    = remainder_q;
    assign done_out         = done_q;
    assign error_out        = error_q;
    assign busy_out         = (state_q != StIdle);

endmodule

// File: tb/tb_div_scheduler.sv
// Randomised bench for div_scheduler; the bench plays the divider and keeps
// an arithmetic reference of grants and per-channel results.
module tb_div_scheduler;

    localparam int W  = 16;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [2*W-1:0] dividend;
    logic [2*W-1:0] divisor;
    logic [W-1:0]   div_dividend;
    logic [W-1:0]   div_divisor;
    logic           div_valid_o;
    logic [W-1:0]   div_quot;
    logic [W-1:0]   div_rem;
    logic           div_valid_i;
    logic           div_err;
    logic [2*W-1:0] quotient;
    logic [2*W-1:0] remainder;
    logic [1:0]     done;
    logic [1:0]     error;
    logic           busy;

    int total = 0;
    int bad   = 0;

    // Reference state: expected slices and last served channel
    logic [W-1:0] exp_q [2];
    logic [W-1:0] exp_r [2];
    logic         exp_e [2];
    int           last;
    int           grants[$];

    always #5 clk = ~clk;

    div_scheduler #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .req_valid_in    (req_valid),
        .req_ready_out   (req_ready),
        .dividend_in     (dividend),
        .divisor_in      (divisor),
        .div_dividend_out(div_dividend),
        .div_divisor_out (div_divisor),
        .div_valid_out   (div_valid_o),
        .div_quotient_in (div_quot),
        .div_remainder_in(div_rem),
        .div_valid_in    (div_valid_i),
        .div_error_in    (div_err),
        .quotient_out    (quotient),
        .remainder_out   (remainder),
        .done_out        (done),
        .error_out       (error),
        .busy_out        (busy)
    );

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            exp_q[i] = '0;
            exp_r[i] = '0;
            exp_e[i] = 1'b0;
        end
        last = 1;
    endfunction

    // One request through to its done cycle. delay<0: divider never answers.
    task automatic run_op(input logic [1:0] req, input logic [W-1:0] a0, input logic [W-1:0] b0,
                          input logic [W-1:0] a1, input logic [W-1:0] b1, input int delay,
                          input logic derr, input bit hold);
        int ch;
        logic [W-1:0] a, b;
        logic [1:0] onehot;
        bit got;
        @(negedge clk);
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b want=0", busy); end
        total++; if (done !== 2'b00) begin bad++; $display("FAIL idle_done got=%b want=00", done); end
        req_valid = req;
        dividend  = {a1, a0};
        divisor   = {b1, b0};
        #1;
        if (req == 2'b11) ch = (last == 1) ? 0 : 1;
        else ch = (req == 2'b10) ? 1 : 0;
        onehot = (ch == 1) ? 2'b10 : 2'b01;
        a = (ch == 1) ? a1 : a0;
        b = (ch == 1) ? b1 : b0;
        grants.push_back(ch);
        total++; if (req_ready !== onehot) begin bad++; $display("FAIL accept_ready got=%b want=%b", req_ready, onehot); end

        @(negedge clk);
        if (!hold) req_valid = 2'b00;
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL issue_ready got=%b want=00", req_ready); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL issue_busy got=%b want=1", busy); end
        total++; if (div_valid_o !== (b != 0)) begin bad++; $display("FAIL issue_start got=%b want=%b", div_valid_o, b != 0); end
        got = 1'b0;
        if (b != 0) begin
            total++; if ({div_dividend, div_divisor} !== {a, b}) begin bad++; $display("FAIL issue_ops got=%0d/%0d want=%0d/%0d", div_dividend, div_divisor, a, b); end
            for (int k = 1; k <= TO; k++) begin
                @(negedge clk);
                div_valid_i = 1'b0;
                div_quot    = W'($urandom);
                div_rem     = W'($urandom);
                div_err     = 1'b1;
                total++; if ({div_valid_o, done, req_ready} !== 5'b0) begin bad++; $display("FAIL wait_quiet got=%b/%b/%b want=0/00/00", div_valid_o, done, req_ready); end
                total++; if ({div_dividend, div_divisor} !== {a, b}) begin bad++; $display("FAIL wait_ops got=%0d/%0d want=%0d/%0d", div_dividend, div_divisor, a, b); end
                if (k == delay) begin
                    div_valid_i = 1'b1;
                    div_quot    = a / b;
                    div_rem     = a % b;
                    div_err     = derr;
                    got         = 1'b1;
                    break;
                end
            end
        end
        @(negedge clk);
        div_valid_i = 1'b0;
        if (got) begin
            exp_q[ch] = a / b;
            exp_r[ch] = a % b;
            exp_e[ch] = derr;
        end else begin
            exp_q[ch] = '0;
            exp_r[ch] = '0;
            exp_e[ch] = 1'b1;
        end
        last = ch;
        total++; if (done !== onehot) begin bad++; $display("FAIL done_pulse got=%b want=%b", done, onehot); end
        total++; if (quotient !== {exp_q[1], exp_q[0]}) begin bad++; $display("FAIL quotient got=%h want=%h", quotient, {exp_q[1], exp_q[0]}); end
        total++; if (remainder !== {exp_r[1], exp_r[0]}) begin bad++; $display("FAIL remainder got=%h want=%h", remainder, {exp_r[1], exp_r[0]}); end
        total++; if (error !== {exp_e[1], exp_e[0]}) begin bad++; $display("FAIL error got=%b want=%b", error, {exp_e[1], exp_e[0]}); end
        total++; if ({div_valid_o, req_ready} !== 3'b0) begin bad++; $display("FAIL respond_quiet got=%b/%b want=0/00", div_valid_o, req_ready); end
        req_valid = 2'b00;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        req_valid = 2'b00;
        div_valid_i = 1'b0;
        @(negedge clk);
        total++; if ({req_ready, div_valid_o, div_dividend, div_divisor, quotient, remainder, done, error, busy} !== '0) begin
            bad++; $display("FAIL reset_outputs got=%b/%b/%h/%h/%h/%h/%b/%b/%b want=all zero", req_ready, div_valid_o, div_dividend, div_divisor, quotient, remainder, done, error, busy);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
    endtask

    task automatic test_single_ch0();
        run_op(2'b01, 16'd1000, 16'd7, 16'd0, 16'd0, 3, 1'b0, 1'b0);
        total++; if (quotient[W-1:0] !== 16'd142 || remainder[W-1:0] !== 16'd6) begin bad++; $display("FAIL ch0_1000_7 got=%0d r%0d want=142 r6", quotient[W-1:0], remainder[W-1:0]); end
    endtask

    task automatic test_both_from_reset();
        apply_reset();
        run_op(2'b11, 16'd600, 16'd3, 16'd400, 16'd4, 2, 1'b0, 1'b1);
        run_op(2'b11, 16'd600, 16'd3, 16'd400, 16'd4, 1, 1'b0, 1'b0);
        total++; if (quotient !== {16'd100, 16'd200}) begin bad++; $display("FAIL both_results got=%h want=006400c8", quotient); end
    endtask

    task automatic test_zero_divisor();
        run_op(2'b10, 16'd5, 16'd1, 16'd77, 16'd0, 1, 1'b0, 1'b0);
        total++; if (error[1] !== 1'b1 || quotient[2*W-1:W] !== '0) begin bad++; $display("FAIL zero_div got=%b/%0d want=1/0", error[1], quotient[2*W-1:W]); end
    endtask

    task automatic test_timeout();
        run_op(2'b01, 16'd99, 16'd9, 16'd0, 16'd0, -1, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++; if (busy !== 1'b0 || done !== 2'b00) begin bad++; $display("FAIL late_resp busy/done got=%b/%b want=0/00", busy, done); end
            div_valid_i = (k < 2);
            div_quot    = 16'h1234;
        end
        div_valid_i = 1'b0;
        total++; if (quotient !== {exp_q[1], exp_q[0]} || error !== {exp_e[1], exp_e[0]}) begin bad++; $display("FAIL late_resp_hold got=%h/%b want=%h/%b", quotient, error, {exp_q[1], exp_q[0]}, {exp_e[1], exp_e[0]}); end
    endtask

    task automatic test_timeout_boundary();
        run_op(2'b10, 16'd0, 16'd0, 16'd1234, 16'd10, TO, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_wait();
        @(negedge clk);
        req_valid = 2'b01;
        dividend  = {16'd0, 16'd50};
        divisor   = {16'd0, 16'd5};
        repeat (3) @(negedge clk);
        req_valid = 2'b00;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        total++; if ({req_ready, div_valid_o, div_dividend, div_divisor, quotient, remainder, done, error, busy} !== '0) begin
            bad++; $display("FAIL midwait_reset got=%b/%b/%h/%h/%h/%b/%b want=all zero", req_ready, div_valid_o, div_dividend, quotient, remainder, done, busy);
        end
        div_valid_i = 1'b1;
        div_quot    = 16'd10;
        @(negedge clk);
        div_valid_i = 1'b0;
        @(negedge clk);
        total++; if (done !== 2'b00 || busy !== 1'b0 || quotient !== '0) begin bad++; $display("FAIL midwait_stale got=%b/%b/%h want=00/0/0", done, busy, quotient); end
    endtask

    task automatic test_alternate();
        int expect_ch;
        apply_reset();
        grants.delete();
        for (int i = 0; i < 6; i++) begin
            run_op(2'b11, W'($urandom), W'($urandom_range(1, 200)), W'($urandom),
                   W'($urandom_range(1, 200)), int'($urandom_range(1, TO)), 1'($urandom_range(0, 1)), 1'b1);
        end
        for (int i = 0; i < 6; i++) begin
            expect_ch = i % 2;
            total++; if (grants[i] !== expect_ch) begin bad++; $display("FAIL alternate_%0d got=%0d want=%0d", i, grants[i], expect_ch); end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] bs [2];
        int dl;
        for (int i = 0; i < 24; i++) begin
            for (int c = 0; c < 2; c++) bs[c] = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom_range(1, 65535));
            dl = ($urandom_range(0, 6) == 0) ? -1 : int'($urandom_range(1, TO));
            run_op(2'($urandom_range(1, 3)), W'($urandom), bs[0], W'($urandom), bs[1], dl,
                   1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        rst         = 1'b1;
        req_valid   = 2'b00;
        dividend    = '0;
        divisor     = '0;
        div_quot    = '0;
        div_rem     = '0;
        div_valid_i = 1'b0;
        div_err     = 1'b0;
        model_reset();
        test_reset();
        test_single_ch0();
        test_both_from_reset();
        test_zero_divisor();
        test_timeout();
        test_timeout_boundary();
        test_reset_mid_wait();
        test_alternate();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
